// File: rtl/bt_uart_cmd_rx_if.sv
// Signal bundle between the Bluetooth UART line and the command receiver.
// The slave side is the receiver; the master side drives the serial line.
`timescale 1ns/1ps
interface bt_uart_cmd_rx_if;
    logic       rxd;
    logic [2:0] signal;
    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;

    modport slave (
        input  rxd,
        output signal,
        output rx_byte,
        output byte_valid,
        output frame_err
    );

    modport master (
        output rxd,
        input  signal,
        input  rx_byte,
        input  byte_valid,
        input  frame_err
    );
endinterface

// File: rtl/bt_uart_cmd_rx.sv
// 8N1 UART receiver that maps ASCII '1'..'7' to a held 3-bit drive command,
// with a watchdog that falls back to STOP (7) when manual commands dry up.
`timescale 1ns/1ps
module bt_uart_cmd_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int TIMEOUT_CYC  = 25000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bt_uart_cmd_rx_if.slave       bus
);
    localparam int BC_W = $clog2(CLKS_PER_BIT);
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [BC_W-1:0] BC_HALF = BC_W'(CLKS_PER_BIT / 2);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(CLKS_PER_BIT - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic [BC_W-1:0] bcnt_q, bcnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err_q, frame_err_d;
    logic [2:0]      signal_q, signal_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            commit;
    logic            is_cmd;
    logic            rxs;

    assign rxs = sync2_q;

    always_comb begin
        sync1_d      = bus.rxd;
        sync2_d      = sync1_q;
        state_d      = state_q;
        bcnt_d       = bcnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        rx_byte_d    = rx_byte_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        signal_d     = signal_q;
        wd_d         = wd_q;
        commit       = 1'b0;
        is_cmd       = (shift_q >= 8'h31) && (shift_q <= 8'h37);

        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d = S_START;
                    bcnt_d  = '0;
                end
            end
            S_START: begin
                // Re-check the line at mid start bit to reject short glitches.
                if (bcnt_q == BC_HALF) begin
                    if (rxs) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        bcnt_d  = '0;
                        idx_d   = 3'd0;
                    end
                end else begin
                    bcnt_d = bcnt_q + BC_W'(1);
                end
            end
            S_DATA: begin
                if (bcnt_q == BC_LAST) begin
                    shift_d = {rxs, shift_q[7:1]};
                    bcnt_d  = '0;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    bcnt_d = bcnt_q + BC_W'(1);
                end
            end
            S_STOP: begin
                if (bcnt_q == BC_LAST) begin
                    bcnt_d = '0;
                    if (rxs) begin
                        commit       = 1'b1;
                        byte_valid_d = 1'b1;
                        rx_byte_d    = shift_q;
                        state_d      = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_IDLE;
                    end
                end else begin
                    bcnt_d = bcnt_q + BC_W'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A fresh command always beats a watchdog expiry in the same cycle.
        if (commit && is_cmd) begin
            signal_d = shift_q[2:0];
            wd_d     = '0;
        end else if (signal_q inside {3'd3, 3'd4, 3'd5, 3'd6}) begin
            if (wd_q == WD_LAST) begin
                signal_d = 3'd7;
                wd_d     = '0;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end else begin
            wd_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            bcnt_q       <= '0;
            idx_q        <= 3'd0;
            shift_q      <= 8'h00;
            rx_byte_q    <= 8'h00;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            signal_q     <= 3'd7;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            bcnt_q       <= bcnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            rx_byte_q    <= rx_byte_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            signal_q     <= signal_d;
            wd_q         <= wd_d;
        end
    end

    assign bus.signal     = signal_q;
    assign bus.rx_byte    = rx_byte_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_bt_uart_cmd_rx.sv
// Directed bench for bt_uart_cmd_rx: a table of well-formed frames plus
// hand-written glitch, framing-error, watchdog and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_bt_uart_cmd_rx;
    localparam int CPB = 16;
    localparam int TOC = 2000;
    localparam int NV  = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bt_uart_cmd_rx_if bus ();

    bt_uart_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYC(TOC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic       gap;
        logic [2:0] exp_sig;
    } vec_t;

    vec_t vecs [NV];

    int total = 0;
    int bad   = 0;

    // Pulse monitor, sampled on the falling edge.
    int         cyc = 0;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         n_both = 0;
    int         valid_cyc = 0;
    logic [7:0] last_byte = 8'h00;
    logic [2:0] sig_at_valid = 3'd0;
    logic [2:0] sig_before_valid = 3'd0;
    logic [2:0] prev_sig = 3'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.byte_valid) begin
                n_valid          = n_valid + 1;
                last_byte        = bus.rx_byte;
                sig_at_valid     = bus.signal;
                sig_before_valid = prev_sig;
                valid_cyc        = cyc;
            end
            if (bus.frame_err) n_ferr = n_ferr + 1;
            if (bus.byte_valid && bus.frame_err) n_both = n_both + 1;
        end
        prev_sig = bus.signal;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        bus.rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            bus.rxd = d[b];
            repeat (CPB) @(negedge clk);
        end
        bus.rxd = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    int nv0, nf0;

    initial begin
        vecs[0]  = '{data: 8'h33, gap: 1'b1, exp_sig: 3'd3};
        vecs[1]  = '{data: 8'h35, gap: 1'b0, exp_sig: 3'd5};
        vecs[2]  = '{data: 8'h41, gap: 1'b1, exp_sig: 3'd5};
        vecs[3]  = '{data: 8'h30, gap: 1'b1, exp_sig: 3'd5};
        vecs[4]  = '{data: 8'h37, gap: 1'b0, exp_sig: 3'd7};
        vecs[5]  = '{data: 8'h0D, gap: 1'b1, exp_sig: 3'd7};
        vecs[6]  = '{data: 8'h38, gap: 1'b1, exp_sig: 3'd7};
        vecs[7]  = '{data: 8'h32, gap: 1'b0, exp_sig: 3'd2};
        vecs[8]  = '{data: 8'h0A, gap: 1'b1, exp_sig: 3'd2};
        vecs[9]  = '{data: 8'h31, gap: 1'b1, exp_sig: 3'd1};
        vecs[10] = '{data: 8'h32, gap: 1'b1, exp_sig: 3'd2};

        bus.rxd = 1'b1;
        rst_n   = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_signal", 32'(bus.signal), 32'd7);
        check("reset_rx_byte", 32'(bus.rx_byte), 32'h00);
        check("reset_byte_valid", 32'(bus.byte_valid), 32'd0);
        check("reset_frame_err", 32'(bus.frame_err), 32'd0);
        rst_n = 1'b1;
        idle(10);

        for (int i = 0; i < NV; i++) begin
            nv0 = n_valid;
            nf0 = n_ferr;
            send_frame(vecs[i].data, 1'b1);
            check($sformatf("vec%0d_valid_pulses", i), 32'(n_valid - nv0), 32'd1);
            check($sformatf("vec%0d_ferr_pulses", i), 32'(n_ferr - nf0), 32'd0);
            check($sformatf("vec%0d_rx_byte", i), 32'(last_byte), 32'(vecs[i].data));
            check($sformatf("vec%0d_sig_at_valid", i), 32'(sig_at_valid), 32'(vecs[i].exp_sig));
            check($sformatf("vec%0d_signal", i), 32'(bus.signal), 32'(vecs[i].exp_sig));
            if (i == 0) check("vec0_sig_before_valid", 32'(sig_before_valid), 32'd7);
            $display("vec %0d: byte=%02h signal=%0d", i, last_byte, bus.signal);
            if (vecs[i].gap) idle(20);
        end

        // Glitch shorter than half a bit must be ignored.
        nv0 = n_valid;
        nf0 = n_ferr;
        bus.rxd = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        check("glitch_valid", 32'(n_valid - nv0), 32'd0);
        check("glitch_ferr", 32'(n_ferr - nf0), 32'd0);
        send_frame(8'h31, 1'b1);
        check("post_glitch_valid", 32'(n_valid - nv0), 32'd1);
        check("post_glitch_byte", 32'(last_byte), 32'h31);
        check("post_glitch_signal", 32'(bus.signal), 32'd1);
        $display("glitch: byte=%02h signal=%0d", last_byte, bus.signal);
        idle(20);

        // Framing error with the line then held low.
        nv0 = n_valid;
        nf0 = n_ferr;
        send_frame(8'h36, 1'b0);
        repeat (40) @(negedge clk);
        check("ferr_pulses", 32'(n_ferr - nf0), 32'd1);
        check("ferr_valid", 32'(n_valid - nv0), 32'd0);
        check("ferr_signal", 32'(bus.signal), 32'd1);
        check("ferr_rx_byte_held", 32'(bus.rx_byte), 32'h31);
        idle(20);
        send_frame(8'h37, 1'b1);
        check("after_ferr_valid", 32'(n_valid - nv0), 32'd1);
        check("after_ferr_signal", 32'(bus.signal), 32'd7);
        $display("frame error: ferr=%0d signal=%0d", n_ferr - nf0, bus.signal);
        idle(20);

        // Watchdog: '4' times out exactly TOC cycles after the commit cycle.
        nv0 = n_valid;
        send_frame(8'h34, 1'b1);
        check("wd_valid", 32'(n_valid - nv0), 32'd1);
        check("wd_sig_at_valid", 32'(sig_at_valid), 32'd4);
        while (cyc < valid_cyc + TOC - 1) @(negedge clk);
        check("wd_before_expiry", 32'(bus.signal), 32'd4);
        @(negedge clk);
        check("wd_after_expiry", 32'(bus.signal), 32'd7);
        $display("watchdog: signal=%0d at cycle %0d", bus.signal, cyc - valid_cyc);
        send_frame(8'h31, 1'b1);
        idle(5000);
        check("wd_auto_mode_hold", 32'(bus.signal), 32'd1);
        $display("autonomous hold: signal=%0d", bus.signal);

        // Reset in the middle of data bit 4 of a 0x32 frame.
        nv0 = n_valid;
        nf0 = n_ferr;
        bus.rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            bus.rxd = (b == 1) ? 1'b1 : 1'b0;
            repeat (CPB) @(negedge clk);
        end
        bus.rxd = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_signal", 32'(bus.signal), 32'd7);
        check("midrst_rx_byte", 32'(bus.rx_byte), 32'h00);
        check("midrst_byte_valid", 32'(bus.byte_valid), 32'd0);
        check("midrst_frame_err", 32'(bus.frame_err), 32'd0);
        idle(200);
        check("midrst_no_valid", 32'(n_valid - nv0), 32'd0);
        check("midrst_no_ferr", 32'(n_ferr - nf0), 32'd0);
        send_frame(8'h32, 1'b1);
        check("midrst_next_byte", 32'(last_byte), 32'h32);
        check("midrst_next_signal", 32'(bus.signal), 32'd2);
        $display("mid-frame reset: byte=%02h signal=%0d", last_byte, bus.signal);
        idle(20);

        check("valid_and_ferr_overlap", 32'(n_both), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bt_uart_cmd_rx.md
Name: bt_uart_cmd_rx

Overview:
UART receiver for the Bluetooth serial module. It deserialises 8N1 bytes from the module's TX line and maps ASCII command bytes to the 3-bit command code (signal[2:0]) that drives the car's mode and motion control logic. It holds the last valid command and includes a link-loss watchdog that forces STOP (7) when manual drive commands stop arriving.

Parameters:
CLKS_PER_BIT, 5208, clk cycles per UART bit (50 MHz / 9600 baud); legal range 8 or more
TIMEOUT_CYC, 25000000, watchdog window in clk cycles (0.5 s at 50 MHz); legal range 1 or more

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  synchronous, active-low reset
rxd  input  1  serial data from the Bluetooth module; idle high; asynchronous to clk
signal  output  3  held command code to the control logic
rx_byte  output  8  last byte received with a good stop bit
byte_valid  output  1  one-cycle pulse when rx_byte updates
frame_err  output  1  one-cycle pulse when a stop bit is sampled low

Behaviour:
- Reset (rst_n=0 at posedge): signal=3'd7, rx_byte=8'h00, byte_valid=0, frame_err=0; FSM to IDLE; all counters 0; synchroniser flops set to 1. A reset mid-frame abandons the frame with no pulse.
- rxd passes through a 2-flop synchroniser; rxs is the synchronised value. All sampling uses rxs.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. A bit counter bcnt counts 0..CLKS_PER_BIT-1; a bit index idx counts 0..7.
- IDLE: when rxs=0, go to START and clear bcnt.
- START: when bcnt reaches CLKS_PER_BIT/2 (integer division), sample rxs.
  - If rxs=1: false start (glitch); return to IDLE with no pulse.
  - If rxs=0: clear bcnt, set idx=0, go to DATA.
- DATA: at each bcnt=CLKS_PER_BIT-1 (mid-bit), shift rxs into the shift register, LSB first, and clear bcnt. After idx=7 is sampled, go to STOP.
- STOP: at bcnt=CLKS_PER_BIT-1, sample rxs.
  - If 1: commit the frame and go to IDLE.
  - If 0: pulse frame_err for 1 cycle, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until rxs=1, then go to IDLE. This covers breaks and line-held-low conditions, and prevents spurious start detection.
- Commit timing: if the stop-bit sample happens on cycle N, then on cycle N+1 rx_byte=shift register and byte_valid=1 (one cycle only). signal updates on the same cycle N+1 if the byte is a command.
- Command map:
  - 8'h31..8'h37 ('1'..'7') give signal = byte[2:0], i.e. 1..7.
  - All other bytes (including '0', CR, LF) still produce rx_byte/byte_valid but leave signal unchanged.
  - A command equal to the current signal is still accepted and restarts the watchdog.
- Watchdog:
  - wd counter clears on every accepted command byte.
  - While signal is in {3,4,5,6}, wd increments each cycle. When wd reaches TIMEOUT_CYC-1, signal becomes 7 on the next cycle and wd clears.
  - While signal is in {1,2,7}, wd is held at 0 (autonomous modes and stop never time out).
- Simultaneous events: if a command commit and a watchdog expiry fall on the same cycle, the commit wins (signal = new command, wd cleared).
- rx_byte is held between frames. byte_valid and frame_err are never asserted on the same cycle.
- Back-to-back frames: a start edge arriving in the cycle after the return to IDLE must be accepted. The receiver sustains continuous 8N1 traffic with no gap needed.

Test Plan (CLKS_PER_BIT=16, TIMEOUT_CYC=2000):
1. Reset, then send 0x33 ('3'). Expect: rx_byte=0x33, a single byte_valid pulse, signal 7->3 on the same cycle as byte_valid, frame_err never set.
2. Send 0x35 then 0x41 ('A') back-to-back with no idle gap. Expect: two byte_valid pulses with rx_byte 0x35 then 0x41; signal=5 after the first byte and unchanged after the second.
3. Drive rxd low for 4 cycles, then high (glitch). Expect: no byte_valid, no frame_err, FSM back in IDLE. A following 0x31 frame is received correctly and signal=1.
4. Send 0x36 with the stop bit forced low, holding rxd low for 40 more cycles. Expect: one frame_err pulse, no byte_valid, signal unchanged. After rxd returns high, 0x37 is received and signal=7.
5. Send 0x34, then idle. Expect: signal stays 4 for 1999 cycles after the commit, then becomes 7. Repeat with 0x31: signal stays 1 indefinitely (run for 5000 cycles).
6. Assert rst_n=0 for one cycle during data bit 4 of a 0x32 frame. Expect: all outputs at reset values, no pulses. The next full 0x32 frame gives signal=2.
